fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the single write port of the 8-bit FIFO (wr_enb/data_in/full/count) among NUM_REQ producers. Each producer uses a valid/ready handshake. A grant lasts for a burst of up to BURST_MAX beats, and the burst is capped by the free space in the FIFO at grant time. The arbiter sits directly in front of the FIFO and is its only writer.

---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter sharing one FIFO write port among NUM_REQ
// valid/ready producers; each grant is capped by BURST_MAX and the FIFO free space.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  input  logic [CNT_W-1:0]            fifo_count,
  output logic                        fifo_wr_enb,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic                        grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BL_W = $clog2(BURST_MAX) + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] grant_id_nxt;
  logic [ID_W-1:0] last_id, last_id_nxt;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] cand;
  logic            pick_found;
  logic [BL_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [BL_W-1:0] burst_len, burst_len_nxt;
  logic [BL_W-1:0] cap_len;
  logic [CNT_W-1:0] free_space;

  // Scan from the producer after the last one served, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_id) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // A grant never promises more beats than the FIFO can absorb right now.
  always_comb begin
    free_space = CNT_W'(DEPTH) - fifo_count;
    if (free_space >= CNT_W'(BURST_MAX)) begin
      cap_len = BL_W'(BURST_MAX);
    end else begin
      cap_len = BL_W'(free_space);
    end
  end

  assign grant_vld = (state == BURST);

  always_comb begin
    req_ready    = '0;
    fifo_wr_enb  = 1'b0;
    fifo_data_in = '0;
    if (state == BURST) begin
      req_ready[grant_id] = !fifo_full;
      fifo_wr_enb         = req_valid[grant_id] & !fifo_full;
      fifo_data_in        = req_data[int'(grant_id)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_id_nxt  = grant_id;
    last_id_nxt   = last_id;
    beat_cnt_nxt  = beat_cnt;
    burst_len_nxt = burst_len;
    case (state)
      IDLE: begin
        if (pick_found && !fifo_full) begin
          state_nxt     = BURST;
          grant_id_nxt  = pick_id;
          burst_len_nxt = cap_len;
          beat_cnt_nxt  = '0;
        end
      end
      BURST: begin
        // A producer that drops valid forfeits the rest of its turn.
        if (!req_valid[grant_id]) begin
          state_nxt   = IDLE;
          last_id_nxt = grant_id;
        end else if (fifo_wr_enb) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (beat_cnt_nxt == burst_len) begin
            state_nxt   = IDLE;
            last_id_nxt = grant_id;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      last_id   <= ID_W'(NUM_REQ - 1);
      beat_cnt  <= '0;
      burst_len <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_id_nxt;
      last_id   <= last_id_nxt;
      beat_cnt  <= beat_cnt_nxt;
      burst_len <= burst_len_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-based producers and FIFO around the DUT, a
// grant/beats-left reference model checked every cycle, plus directed scenarios.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 8;
  localparam int CNT_W     = 4;
  localparam int BURST_MAX = 4;
  localparam int ID_W      = $clog2(NUM_REQ);

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0]  req_data = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       fifo_full;
  logic [CNT_W-1:0]           fifo_count = '0;
  logic                       fifo_wr_enb;
  logic [DATA_W-1:0]          fifo_data_in;
  logic                       grant_vld;
  logic [ID_W-1:0]            grant_id;

  logic size_full = 1'b0;
  logic force_full = 1'b0;
  logic drain = 1'b0;
  assign fifo_full = size_full | force_full;

  logic [DATA_W-1:0] pq [NUM_REQ][$];
  logic [DATA_W-1:0] fq [$];
  logic [NUM_REQ-1:0] prod_acc;

  int checks = 0;
  int errors = 0;

  logic            m_active = 1'b0;
  logic [ID_W-1:0] m_owner = '0;
  logic [ID_W-1:0] m_ptr = '0;
  logic [ID_W-1:0] m_cand;
  logic            m_found;
  int              m_left = 0;
  int              m_free;
  logic [NUM_REQ-1:0] e_ready;
  logic               e_wr;
  logic [DATA_W-1:0]  e_data;

  logic prev_gv = 1'b0;
  int cur_beats = 0;
  int stall_cnt = 0;
  int grant_log [32];
  int grant_n = 0;
  int burst_log [32];
  int burst_n = 0;
  logic [DATA_W-1:0] wr_log [64];
  int wr_n = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .CNT_W(CNT_W), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .fifo_count(fifo_count),
    .fifo_wr_enb(fifo_wr_enb),
    .fifo_data_in(fifo_data_in),
    .grant_vld(grant_vld),
    .grant_id(grant_id)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Producers pop an item on an accepted handshake and present the next one.
  always @(posedge clk) begin
    prod_acc = req_valid & req_ready;
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (prod_acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      req_valid[i] = (pq[i].size() > 0);
      req_data[i*DATA_W +: DATA_W] = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
  end

  always @(posedge clk) begin
    if (drain && fq.size() > 0) void'(fq.pop_front());
    if (fifo_wr_enb) fq.push_back(fifo_data_in);
    fifo_count <= CNT_W'(fq.size());
    size_full  <= (fq.size() >= DEPTH);
  end

  // Reference model: who owns the port and how many beats remain in the turn.
  always @(negedge clk) begin
    if (!rst) begin
      m_active = 1'b0;
      m_owner  = '0;
      m_ptr    = ID_W'(NUM_REQ - 1);
      m_left   = 0;
      check_output("rst_req_ready", req_ready, 0);
      check_output("rst_wr_enb", fifo_wr_enb, 0);
      check_output("rst_grant_vld", grant_vld, 0);
      check_output("rst_grant_id", grant_id, 0);
      check_output("rst_data_in", fifo_data_in, 0);
    end else begin
      e_ready = '0;
      e_wr    = 1'b0;
      e_data  = '0;
      if (m_active) begin
        e_ready[m_owner] = !fifo_full;
        e_wr   = req_valid[m_owner] && !fifo_full;
        e_data = req_data[m_owner*DATA_W +: DATA_W];
      end
      check_output("req_ready", req_ready, e_ready);
      check_output("fifo_wr_enb", fifo_wr_enb, e_wr);
      check_output("fifo_data_in", fifo_data_in, e_data);
      check_output("grant_vld", grant_vld, m_active);
      check_output("grant_id", grant_id, m_owner);

      if (grant_vld && !prev_gv) begin
        if (grant_n < 32) grant_log[grant_n] = int'(grant_id);
        grant_n++;
        cur_beats = 0;
      end
      if (fifo_wr_enb) begin
        if (wr_n < 64) wr_log[wr_n] = fifo_data_in;
        wr_n++;
        cur_beats++;
      end
      if (grant_vld && !fifo_wr_enb && req_valid[grant_id]) stall_cnt++;
      if (!grant_vld && prev_gv) begin
        if (burst_n < 32) burst_log[burst_n] = cur_beats;
        burst_n++;
      end

      if (m_active) begin
        if (!req_valid[m_owner]) begin
          m_active = 1'b0;
          m_ptr    = m_owner;
        end else if (e_wr) begin
          m_left--;
          if (m_left == 0) begin
            m_active = 1'b0;
            m_ptr    = m_owner;
          end
        end
      end else if (req_valid != '0 && !fifo_full) begin
        m_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          m_cand = ID_W'((int'(m_ptr) + k) % NUM_REQ);
          if (!m_found && req_valid[m_cand]) begin
            m_found = 1'b1;
            m_owner = m_cand;
          end
        end
        m_free   = DEPTH - int'(fifo_count);
        m_left   = (m_free < BURST_MAX) ? m_free : BURST_MAX;
        m_active = 1'b1;
      end
    end
    prev_gv = grant_vld;
  end

  task automatic clear_logs();
    grant_n   = 0;
    burst_n   = 0;
    wr_n      = 0;
    stall_cnt = 0;
  endtask

  task automatic apply_reset();
    rst        = 1'b0;
    drain      = 1'b0;
    force_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    fq.delete();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2;
    clear_logs();
  endtask

  task automatic apply_stimulus(input int p, input logic [DATA_W-1:0] base, input int n);
    for (int k = 0; k < n; k++) pq[p].push_back(DATA_W'(int'(base) + k));
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_wr(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (fifo_wr_enb !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output(name, fifo_wr_enb, 1);
  endtask

  initial begin
    #1;
    apply_reset();
    check_output("t0_grant_vld", grant_vld, 0);
    check_output("t0_req_ready", req_ready, 0);

    // Single producer 2 fills an empty FIFO in two bursts, then is held off.
    apply_stimulus(2, 8'h10, 9);
    run_cycles(40);
    check_output("t1_grant_n", grant_n, 2);
    check_output("t1_grant0", grant_log[0], 2);
    check_output("t1_grant1", grant_log[1], 2);
    check_output("t1_burst_n", burst_n, 2);
    check_output("t1_burst0", burst_log[0], 4);
    check_output("t1_burst1", burst_log[1], 4);
    check_output("t1_wr_n", wr_n, 8);
    for (int k = 0; k < 8; k++) check_output($sformatf("t1_wr%0d", k), wr_log[k], 8'h10 + k);
    check_output("t1_count", fifo_count, 8);
    check_output("t1_ready_held", req_ready, 0);

    // All four producers busy with a draining FIFO: strict rotation.
    apply_reset();
    drain = 1'b1;
    for (int p = 0; p < NUM_REQ; p++) apply_stimulus(p, DATA_W'(8'h40 + p*16), 8);
    run_cycles(60);
    check_output("t2_grant_n", grant_n, 8);
    for (int i = 0; i < 8; i++) check_output($sformatf("t2_grant%0d", i), grant_log[i], i % 4);
    for (int i = 0; i < 8; i++) check_output($sformatf("t2_burst%0d", i), burst_log[i], 4);
    check_output("t2_wr_n", wr_n, 32);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < 4; k++)
          check_output($sformatf("t2_wr_r%0d_p%0d_%0d", r, p, k),
                       wr_log[r*16 + p*4 + k], 8'h40 + p*16 + r*4 + k);

    // Burst capped by free space, next grant waits for room.
    apply_reset();
    for (int k = 0; k < 6; k++) fq.push_back(8'hEE);
    run_cycles(2);
    apply_stimulus(0, 8'h30, 4);
    run_cycles(12);
    check_output("t3_burst_n", burst_n, 1);
    check_output("t3_burst0", burst_log[0], 2);
    check_output("t3_wr_n", wr_n, 2);
    check_output("t3_wr0", wr_log[0], 8'h30);
    check_output("t3_wr1", wr_log[1], 8'h31);
    check_output("t3_idle_full", grant_vld, 0);
    drain = 1'b1;
    @(posedge clk);
    #2 drain = 1'b0;
    run_cycles(10);
    check_output("t3_grant_n", grant_n, 2);
    check_output("t3_burst1", burst_log[1], 1);
    check_output("t3_wr2", wr_log[2], 8'h32);

    // Producer 1 drops valid after two beats; rotation continues at 2.
    apply_reset();
    drain = 1'b1;
    apply_stimulus(1, 8'h21, 2);
    apply_stimulus(2, 8'h31, 4);
    apply_stimulus(3, 8'h41, 4);
    run_cycles(30);
    check_output("t4_grant_n", grant_n, 3);
    check_output("t4_grant0", grant_log[0], 1);
    check_output("t4_grant1", grant_log[1], 2);
    check_output("t4_grant2", grant_log[2], 3);
    check_output("t4_burst0", burst_log[0], 2);
    check_output("t4_burst1", burst_log[1], 4);
    check_output("t4_burst2", burst_log[2], 4);
    check_output("t4_wr_n", wr_n, 10);

    // Asynchronous reset mid-burst, then priority restarts at producer 0.
    apply_reset();
    apply_stimulus(2, 8'h50, 4);
    wait_wr("t5_first_beat");
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_output("t5_async_grant_vld", grant_vld, 0);
    check_output("t5_async_ready", req_ready, 0);
    check_output("t5_async_wr", fifo_wr_enb, 0);
    check_output("t5_async_data", fifo_data_in, 0);
    check_output("t5_async_gid", grant_id, 0);
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    check_output("t5_kept_beat", fifo_count, 1);
    clear_logs();
    apply_stimulus(1, 8'h60, 4);
    apply_stimulus(3, 8'h70, 4);
    run_cycles(25);
    check_output("t5_grant_n", grant_n, 2);
    check_output("t5_grant0", grant_log[0], 1);
    check_output("t5_grant1", grant_log[1], 3);
    check_output("t5_burst0", burst_log[0], 4);
    check_output("t5_burst1", burst_log[1], 3);

    // FIFO full for three cycles mid-burst: stall without loss or repeat.
    apply_reset();
    apply_stimulus(0, 8'hA0, 4);
    wait_wr("t6_first_beat");
    @(posedge clk);
    #2 force_full = 1'b1;
    repeat (3) @(posedge clk);
    #2 force_full = 1'b0;
    run_cycles(15);
    check_output("t6_stalls", stall_cnt, 3);
    check_output("t6_burst_n", burst_n, 1);
    check_output("t6_burst0", burst_log[0], 4);
    check_output("t6_wr_n", wr_n, 4);
    for (int k = 0; k < 4; k++) check_output($sformatf("t6_wr%0d", k), wr_log[k], 8'hA0 + k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
